// File: rtl/db_multi.sv
// db_multi: N-channel button debouncer; 2-flop sync, per-channel stability filter,
// registered press/release pulses and an optional long-press hold pulse.
module db_multi #(
    parameter int CHANNELS      = 4,
    parameter int STABLE_CYCLES = 1000000,
    parameter int HOLD_CYCLES   = 50000000,
    parameter int ACTIVE_LOW    = 0
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic [CHANNELS-1:0] button_in,
    output logic [CHANNELS-1:0] out,
    output logic [CHANNELS-1:0] press,
    output logic [CHANNELS-1:0] released,
    output logic [CHANNELS-1:0] hold
);
    localparam int SW = $clog2(STABLE_CYCLES + 1);
    localparam logic [SW-1:0] SC_END = SW'(STABLE_CYCLES - 1);

    logic [CHANNELS-1:0] s1, s2, flip;
    logic [SW-1:0] sc [CHANNELS];

    always_comb begin
        flip = '0;
        for (int i = 0; i < CHANNELS; i++)
            flip[i] = s2[i] != out[i] && sc[i] == SC_END;
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            s1       <= '0;
            s2       <= '0;
            out      <= '0;
            press    <= '0;
            released <= '0;
            for (int i = 0; i < CHANNELS; i++) sc[i] <= '0;
        end else begin
            s1       <= ACTIVE_LOW != 0 ? ~button_in : button_in;
            s2       <= s1;
            out      <= out ^ flip;
            press    <= flip & s2;
            released <= flip & ~s2;
            // any return to the current level restarts the stability window
            for (int i = 0; i < CHANNELS; i++)
                sc[i] <= (s2[i] == out[i] || flip[i]) ? '0 : sc[i] + 1'b1;
        end
    end

    if (HOLD_CYCLES > 0) begin : g_hold
        localparam int HW = $clog2(HOLD_CYCLES + 1);
        localparam logic [HW-1:0] HC_MAX = HW'(HOLD_CYCLES);
        logic [HW-1:0] hc [CHANNELS];
        always_ff @(posedge clk) begin
            if (!rst_n) begin
                hold <= '0;
                for (int i = 0; i < CHANNELS; i++) hc[i] <= '0;
            end else begin
                // hc saturates so hold fires once per press; suppressed on the release edge
                for (int i = 0; i < CHANNELS; i++) begin
                    hc[i]   <= !out[i] ? '0 : hc[i] == HC_MAX ? hc[i] : hc[i] + 1'b1;
                    hold[i] <= out[i] && !flip[i] && hc[i] == HC_MAX - 1'b1;
                end
            end
        end
    end else begin : g_nohold
        assign hold = '0;
    end
endmodule

// File: tb/tb_db_multi.sv
// tb_db_multi: directed stimulus; a window-based reference model is checked every cycle,
// plus literal event-timing expectations for each scenario.
module tb_db_multi;
    localparam int ST = 8;
    localparam int HD = 32;

    logic       clk = 0;
    logic       rst_n = 0;
    logic [1:0] button_in = 2'b11;
    logic [1:0] out, press, released, hold;
    logic [0:0] bl_in = 1'b1;
    logic [0:0] bl_out, bl_press, bl_rel, bl_hold;

    db_multi #(.CHANNELS(2), .STABLE_CYCLES(ST), .HOLD_CYCLES(HD), .ACTIVE_LOW(0)) dut (
        .clk(clk), .rst_n(rst_n), .button_in(button_in),
        .out(out), .press(press), .released(released), .hold(hold)
    );

    db_multi #(.CHANNELS(1), .STABLE_CYCLES(ST), .HOLD_CYCLES(0), .ACTIVE_LOW(1)) dut_low (
        .clk(clk), .rst_n(rst_n), .button_in(bl_in),
        .out(bl_out), .press(bl_press), .released(bl_rel), .hold(bl_hold)
    );

    always #5 clk = ~clk;

    int         cyc = 0;
    logic [1:0] raw_q = 2'b00;
    logic       rst_q = 1'b0;

    always @(posedge clk) begin
        cyc   <= cyc + 1;
        raw_q <= button_in;
        rst_q <= rst_n;
    end

    int checks = 0, errors = 0;
    logic [1:0] rawh[$];
    logic [1:0] sq[$];
    logic [1:0] om = '0, ep = '0, er = '0, eh = '0;
    int pe[2] = '{0, 0};
    int lp[2] = '{-1, -1}, lr[2] = '{-1, -1}, lh[2] = '{-1, -1};
    int np[2] = '{0, 0}, nr[2] = '{0, 0}, nh[2] = '{0, 0};
    int lpl = -1, nhl = 0;
    int t, n, n2;

    task automatic chk(input string nm, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s at cycle %0d: got %0d, expected %0d", nm, cyc, act, exp);
        end
    endtask

    // Model: the synchroniser is a 2-edge delay of the pin; the level flips on the edge
    // where the last ST synchronised samples all disagree with the current level.
    task automatic tick();
        logic [1:0] s;
        logic       fl;
        @(negedge clk);
        if (!rst_q) begin
            rawh.delete();
            sq.delete();
            om = '0; ep = '0; er = '0; eh = '0;
        end else begin
            rawh.push_back(raw_q);
            s = rawh.size() >= 3 ? rawh[rawh.size()-3] : 2'b00;
            if (rawh.size() > 3) void'(rawh.pop_front());
            sq.push_back(s);
            if (sq.size() > ST) void'(sq.pop_front());
            for (int c = 0; c < 2; c++) begin
                fl = sq.size() == ST;
                foreach (sq[j]) if (sq[j][c] == om[c]) fl = 1'b0;
                ep[c] = fl && !om[c];
                er[c] = fl && om[c];
                eh[c] = om[c] && !fl && (cyc - pe[c] == HD);
                if (ep[c]) pe[c] = cyc;
                om[c] = om[c] ^ fl;
            end
        end
        chk("out", out, om);
        chk("press", press, ep);
        chk("release", released, er);
        chk("hold", hold, eh);
        for (int c = 0; c < 2; c++) begin
            if (press[c])    begin lp[c] = cyc; np[c]++; end
            if (released[c]) begin lr[c] = cyc; nr[c]++; end
            if (hold[c])     begin lh[c] = cyc; nh[c]++; end
        end
        if (bl_press[0]) lpl = cyc;
        if (bl_hold[0]) nhl++;
    endtask

    task automatic run(input int k);
        repeat (k) tick();
    endtask

    initial begin
        // reset with both buttons held, then both press together
        run(4);
        chk("rst_out", out, 0);
        rst_n = 1'b1;
        t = cyc;
        run(12);
        chk("t1_press0_edge", lp[0], t + 10);
        chk("t1_press1_edge", lp[1], t + 10);
        chk("t1_out", out, 3);
        chk("t6_idle_out", bl_out, 0);
        button_in = 2'b00;
        t = cyc;
        run(12);
        chk("t1_rel0_edge", lr[0], t + 10);
        chk("t1_rel1_edge", lr[1], t + 10);
        chk("t1_no_hold", nh[1], 0);
        // clean press / release on ch0
        button_in[0] = 1'b1;
        t = cyc;
        run(12);
        chk("t2_press_edge", lp[0], t + 10);
        chk("t2_out", out[0], 1);
        button_in[0] = 1'b0;
        t = cyc;
        run(12);
        chk("t2_rel_edge", lr[0], t + 10);
        // bounce, then settle high; then a 7-cycle glitch
        n = np[0];
        n2 = nr[0];
        for (int i = 0; i < 10; i++) begin
            button_in[0] = (i % 2 == 0);
            run(3);
        end
        button_in[0] = 1'b1;
        t = cyc;
        run(12);
        chk("t3_press_edge", lp[0], t + 10);
        chk("t3_single_press", np[0] - n, 1);
        chk("t3_no_release", nr[0] - n2, 0);
        n = nr[0];
        button_in[0] = 1'b0;
        run(7);
        button_in[0] = 1'b1;
        run(12);
        chk("t3_glitch_ignored", nr[0] - n, 0);
        chk("t3_out_kept", out[0], 1);
        button_in[0] = 1'b0;
        run(12);
        // long hold on ch1, then a short hold
        n = nh[1];
        button_in[1] = 1'b1;
        t = cyc;
        run(60);
        chk("t4_press_edge", lp[1], t + 10);
        chk("t4_hold_edge", lh[1], t + 42);
        chk("t4_hold_once", nh[1] - n, 1);
        button_in[1] = 1'b0;
        t = cyc;
        run(12);
        chk("t4_rel_edge", lr[1], t + 10);
        n = nh[1];
        button_in[1] = 1'b1;
        run(20);
        button_in[1] = 1'b0;
        run(14);
        chk("t4_short_no_hold", nh[1] - n, 0);
        // independence: ch0 press and ch1 release on the same edge
        button_in[1] = 1'b1;
        run(12);
        button_in = 2'b01;
        t = cyc;
        run(12);
        chk("t5_press0_edge", lp[0], t + 10);
        chk("t5_rel1_edge", lr[1], t + 10);
        // active-low instance
        bl_in = 1'b0;
        t = cyc;
        run(12);
        chk("t6_press_edge", lpl, t + 10);
        chk("t6_out", bl_out, 1);
        bl_in = 1'b1;
        run(12);
        // reset mid-count with inputs held
        button_in = 2'b11;
        run(5);
        rst_n = 1'b0;
        run(3);
        chk("t7_rst_out", out, 0);
        rst_n = 1'b1;
        t = cyc;
        run(12);
        chk("t7_press0_edge", lp[0], t + 10);
        chk("t7_press1_edge", lp[1], t + 10);
        run(40);
        chk("t7_hold0_edge", lh[0], t + 42);
        chk("t6_hold_tied", nhl, 0);
        $display("End of test - %0d assertions evaluated, %0d failures", checks, errors);
        $finish;
    end
endmodule
